// File: rtl/lpc_frame_packer.sv
// Packs 16-bit LPC parameter words five at a time into 80-bit AXI4-Stream beats,
// with TUSER on the first beat of a packet and TLAST on the last beat or on a flush.
module lpc_frame_packer #(
    parameter int WORDS_PER_BEAT = 5,
    parameter int BEATS_PER_PKT  = 1920,
    parameter int CNT_W          = 11
) (
    input  logic                          ACLK,
    input  logic                          ARESET_N,
    input  logic                          EN,
    input  logic [15:0]                   IN_DATA,
    input  logic                          IN_VALID,
    output logic                          IN_READY,
    input  logic                          IN_LAST,
    output logic [16*WORDS_PER_BEAT-1:0]  TDATA,
    output logic                          TVALID,
    input  logic                          TREADY,
    output logic                          TLAST,
    output logic                          TUSER
);

    localparam int DW     = 16 * WORDS_PER_BEAT;
    localparam int PW     = DW - 16;
    localparam int WCNT_W = $clog2(WORDS_PER_BEAT);
    localparam logic [WCNT_W-1:0] WCNT_FULL = WCNT_W'(WORDS_PER_BEAT - 1);
    localparam logic [CNT_W-1:0]  BCNT_LAST = CNT_W'(BEATS_PER_PKT - 1);

    logic [PW-1:0]     pack_reg;
    logic [WCNT_W-1:0] wcnt_reg;
    logic [CNT_W-1:0]  bcnt_reg;
    logic [DW-1:0]     tdata_reg;
    logic              tvalid_reg;
    logic              tlast_reg;
    logic              tuser_reg;

    logic          out_free;
    logic          in_ready;
    logic          accept;
    logic          load;
    logic          load_last;
    logic [DW-1:0] beat_data;

    assign out_free = !tvalid_reg || TREADY;

    // A flush with fewer than five words still needs the output register, so
    // it waits for a free output slot just like the fifth word does.
    assign in_ready = ARESET_N && EN &&
                      (out_free || ((wcnt_reg != WCNT_FULL) && !IN_LAST));
    assign accept   = IN_VALID && in_ready;
    assign load     = accept && (IN_LAST || (wcnt_reg == WCNT_FULL));
    assign load_last = IN_LAST || (bcnt_reg == BCNT_LAST);

    // Older words sit above newer ones in pack_reg; shifting left drops the
    // unused upper slots and zero-fills the tail of a short beat.
    assign beat_data = {pack_reg, IN_DATA} << (16 * (WORDS_PER_BEAT - 1 - int'(wcnt_reg)));

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            pack_reg   <= '0;
            wcnt_reg   <= '0;
            bcnt_reg   <= '0;
            tdata_reg  <= '0;
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
            tuser_reg  <= 1'b0;
        end else if (load) begin
            tdata_reg  <= beat_data;
            tvalid_reg <= 1'b1;
            tlast_reg  <= load_last;
            tuser_reg  <= (bcnt_reg == '0);
            bcnt_reg   <= load_last ? '0 : bcnt_reg + CNT_W'(1);
            pack_reg   <= '0;
            wcnt_reg   <= '0;
        end else begin
            if (accept) begin
                pack_reg <= {pack_reg[PW-17:0], IN_DATA};
                wcnt_reg <= wcnt_reg + WCNT_W'(1);
            end
            if (tvalid_reg && TREADY) begin
                tvalid_reg <= 1'b0;
            end
        end
    end

    assign IN_READY = in_ready;
    assign TDATA    = tdata_reg;
    assign TVALID   = tvalid_reg;
    assign TLAST    = tlast_reg;
    assign TUSER    = tuser_reg;

endmodule
